// File: rtl/spart_echo_driver_pkg.sv
// Shared types, bus address map and baud divisor helper for the spart echo driver.
package spart_echo_driver_pkg;

  typedef enum logic [1:0] {
    CFG_LO = 2'b00,
    CFG_HI = 2'b01,
    RUN    = 2'b10
  } drv_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // Divisor = clk_hz / baud rounded to nearest; sel picks 4800 << sel.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned baud;
    baud = 32'd4800 << sel;
    return 16'((clk_hz + (baud / 32'd2)) / baud);
  endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// Processor-side spart bus (minus the tri-state data lines, which stay a plain inout port).
//  iocs/iorw/ioaddr : master -> spart
//  rda/tbr          : spart -> master
interface spart_echo_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_echo_driver_fifo.sv
// Echo buffer: power-of-2 FIFO with wrap-bit pointers and show-ahead head.
//  i_push/i_din : write side; dropped when full unless popping in the same cycle
//  i_pop/o_dout : read side; o_dout is the current head
//  o_empty/o_full : occupancy flags
module spart_echo_driver_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = i_push && (!o_full || i_pop);
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; simultaneous push/pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/spart_echo_driver.sv
// Bus master for spart: programs the baud divisor, then echoes every received byte.
//  clk, rst        : clock, async active-low reset
//  br_cfg          : async baud select, synchronised internally
//  bus (master)    : iocs/iorw/ioaddr out, rda/tbr in
//  databus         : tri-state data, driven only while writing
//  overflow        : sticky receive-drop flag
//  rx_last         : last byte sampled from spart
module spart_echo_driver
  import spart_echo_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          br_cfg,
  spart_echo_driver_if.master bus,
  inout  wire  [7:0]          databus,
  output logic                overflow,
  output logic [7:0]          rx_last
);

  localparam logic [15:0] DIV_RST = baud_div(CLK_HZ, 2'b00);

  drv_state_t  r_state;
  drv_state_t  w_state_nxt;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_cfg_in_use;
  logic [15:0] r_div;
  logic        r_reconfig_pend;
  logic        r_tx_wait;
  logic        r_overflow;
  logic [7:0]  r_rx_last;

  logic        w_iocs;
  logic        w_iorw;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_dout;
  logic        w_we;
  logic        w_capture;
  logic        w_push;
  logic        w_cfg_entry;
  logic [7:0]  w_fifo_dout;
  logic        w_empty;
  logic        w_full;

  // Two-flop synchroniser for the asynchronous baud select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= br_cfg;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CFG_LO;
    else      r_state <= w_state_nxt;
  end

  // Next state and bus outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_iocs      = 1'b0;
    w_iorw      = 1'b1;
    w_ioaddr    = ADDR_DATA;
    w_dout      = 8'h00;
    w_we        = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      CFG_LO: begin
        w_state_nxt = CFG_HI;
        w_iocs      = 1'b1;
        w_iorw      = 1'b0;
        w_ioaddr    = ADDR_DIV_LO;
        w_dout      = r_div[7:0];
      end
      CFG_HI: begin
        w_state_nxt = RUN;
        w_iocs      = 1'b1;
        w_iorw      = 1'b0;
        w_ioaddr    = ADDR_DIV_HI;
        w_dout      = r_div[15:8];
      end
      RUN: begin
        // Capture has priority over echo; tx_wait holds off a second write until tbr drops.
        w_capture = bus.rda;
        w_we      = bus.tbr && !w_empty && !bus.rda && !r_tx_wait;
        if (w_we) begin
          w_iocs = 1'b1;
          w_iorw = 1'b0;
          w_dout = w_fifo_dout;
        end
        // Reprogram only once the last echo has actually been accepted by spart.
        if (r_reconfig_pend && w_empty && bus.tbr && !r_tx_wait) w_state_nxt = CFG_LO;
      end
      default: w_state_nxt = CFG_LO;
    endcase
    // Bus is quiet for the whole time reset is asserted, regardless of state.
    if (!rst) begin
      w_iocs   = 1'b0;
      w_iorw   = 1'b1;
      w_ioaddr = ADDR_DATA;
    end
  end

  assign w_push      = w_capture && !w_full;
  assign w_cfg_entry = (r_state == RUN) && (w_state_nxt == CFG_LO);

  // Divisor selection; reset value matches the reset value of the synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_in_use    <= 2'b00;
      r_div           <= DIV_RST;
      r_reconfig_pend <= 1'b0;
    end else if (w_cfg_entry) begin
      r_cfg_in_use    <= r_sync2;
      r_div           <= baud_div(CLK_HZ, r_sync2);
      r_reconfig_pend <= 1'b0;
    end else if (r_sync2 != r_cfg_in_use) begin
      r_reconfig_pend <= 1'b1;
    end
  end

  // tbr lags a data write by a cycle; wait to see it low before the next write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_tx_wait <= 1'b0;
    else if (w_we)     r_tx_wait <= 1'b1;
    else if (!bus.tbr) r_tx_wait <= 1'b0;
  end

  // Receive sampling and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_rx_last  <= 8'h00;
    end else if (w_capture) begin
      r_rx_last <= databus;
      if (w_full) r_overflow <= 1'b1;
    end
  end

  spart_echo_driver_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_we),
    .i_din   (databus),
    .o_dout  (w_fifo_dout),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.iocs   = w_iocs;
  assign bus.iorw   = w_iorw;
  assign bus.ioaddr = w_ioaddr;
  assign databus    = w_iorw ? 8'hzz : w_dout;
  assign overflow   = r_overflow;
  assign rx_last    = r_rx_last;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Directed bench for spart_echo_driver with a minimal spart bus model.
module tb_spart_echo_driver;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       overflow;
  logic [7:0] rx_last;
  logic [7:0] tb_byte;
  wire  [7:0] databus;

  int n_checks;
  int n_errs;

  logic [9:0] wr_log[$];
  logic [9:0] exp_log[$];

  spart_echo_driver_if bus ();

  spart_echo_driver #(
    .CLK_HZ     (50_000_000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus),
    .databus  (databus),
    .overflow (overflow),
    .rx_last  (rx_last)
  );

  // spart model drives the data lines whenever the master is not writing.
  assign databus = bus.iorw ? tb_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every bus write seen by spart, as {ioaddr, data}.
  always @(posedge clk) begin
    if (rst && bus.iocs && !bus.iorw) wr_log.push_back({bus.ioaddr, databus});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs applied on the falling edge, outputs settled 1ns later.
  task automatic cyc(input logic rda, input logic tbr, input logic [7:0] b);
    @(negedge clk);
    bus.rda = rda;
    bus.tbr = tbr;
    tb_byte = b;
    #1;
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s_count", tag), 32'(wr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_log[i]));
    wr_log.delete();
    exp_log.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_iocs"}, 32'(bus.iocs), 32'd0);
    check({tag, "_iorw"}, 32'(bus.iorw), 32'd1);
    check({tag, "_ioaddr"}, 32'(bus.ioaddr), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst      = 1'b0;
    br_cfg   = 2'b01;
    bus.rda  = 1'b0;
    bus.tbr  = 1'b1;
    tb_byte  = 8'hA5;

    // Reset values.
    repeat (3) cyc(1'b0, 1'b1, 8'hA5);
    check_idle("rst");
    check("rst_databus_released", 32'(databus), 32'hA5);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rx_last", 32'(rx_last), 32'd0);

    // Synchroniser resets to 00, so the first program is 4800 baud (10417 = 0x28B1),
    // followed by a reprogram to the 9600 divisor (5208 = 0x1458).
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("cfg1_ioaddr", 32'(bus.ioaddr), 32'd2);
    check("cfg1_iocs", 32'(bus.iocs), 32'd1);
    check("cfg1_iorw", 32'(bus.iorw), 32'd0);
    check("cfg1_data", 32'(databus), 32'hB1);
    repeat (12) cyc(1'b0, 1'b1, 8'hA5);
    check_idle("run_idle");
    exp_log = '{10'h2B1, 10'h328, 10'h258, 10'h314};
    check_log("init_cfg");

    // Single echo of 0x41.
    cyc(1'b1, 1'b1, 8'h41);
    check("b_no_wr_on_rda", 32'(bus.iocs), 32'd0);
    cyc(1'b0, 1'b1, 8'hA5);
    check("b_rx_last", 32'(rx_last), 32'h41);
    check("b_wr_iocs", 32'(bus.iocs), 32'd1);
    check("b_wr_iorw", 32'(bus.iorw), 32'd0);
    check("b_wr_ioaddr", 32'(bus.ioaddr), 32'd0);
    check("b_wr_data", 32'(databus), 32'h41);
    cyc(1'b0, 1'b1, 8'hA5);
    check("b_tx_wait", 32'(bus.iocs), 32'd0);
    cyc(1'b0, 1'b0, 8'hA5);
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 8'hA5);
    exp_log = '{10'h041};
    check_log("single");

    // Nine bytes with tbr low: eight stored, ninth dropped.
    cyc(1'b0, 1'b0, 8'hA5);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      cyc(1'b0, 1'b0, 8'hA5);
      if (i == 8) check("c_no_ovf_at8", 32'(overflow), 32'd0);
    end
    check("c_overflow", 32'(overflow), 32'd1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 8'hA5);
      check($sformatf("c_echo%0d", k), 32'(databus), 32'(k + 1));
      cyc(1'b0, 1'b1, 8'hA5);
      check($sformatf("c_block%0d", k), 32'(bus.iocs), 32'd0);
      cyc(1'b0, 1'b0, 8'hA5);
    end
    repeat (3) cyc(1'b0, 1'b1, 8'hA5);
    check("c_empty_no_wr", 32'(bus.iocs), 32'd0);
    check("c_ovf_sticky", 32'(overflow), 32'd1);
    for (int k = 0; k < 8; k++) exp_log.push_back(10'(k + 1));
    check_log("burst");

    // rda and tbr together: capture first, queued 0x10 written the next cycle.
    cyc(1'b0, 1'b0, 8'hA5);
    cyc(1'b1, 1'b0, 8'h10);
    cyc(1'b0, 1'b0, 8'hA5);
    cyc(1'b1, 1'b1, 8'h22);
    check("d_capture_wins", 32'(bus.iocs), 32'd0);
    cyc(1'b0, 1'b1, 8'hA5);
    check("d_rx_last", 32'(rx_last), 32'h22);
    check("d_wr_10", 32'(databus), 32'h10);
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b0, 8'hA5);
    cyc(1'b0, 1'b1, 8'hA5);
    check("d_wr_22", 32'(databus), 32'h22);
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b0, 8'hA5);
    exp_log = '{10'h010, 10'h022};
    check_log("collide");

    // Baud change 01 -> 11 with three bytes queued; 38400 divisor is 1302 = 0x0516.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h31 + i));
      cyc(1'b0, 1'b0, 8'hA5);
    end
    br_cfg = 2'b11;
    repeat (4) cyc(1'b0, 1'b0, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 8'hA5);
      cyc(1'b0, 1'b1, 8'hA5);
      cyc(1'b0, 1'b0, 8'hA5);
    end
    repeat (6) cyc(1'b0, 1'b1, 8'hA5);
    check_idle("e_idle");
    exp_log = '{10'h031, 10'h032, 10'h033, 10'h216, 10'h305};
    check_log("reconfig");

    // Reset in the middle of an echo write.
    cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b0, 1'b0, 8'hA5);
    cyc(1'b0, 1'b1, 8'hA5);
    check("f_pre_wr", 32'(bus.iocs), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_idle("f_rst");
    check("f_databus_released", 32'(databus), 32'hA5);
    check("f_overflow_clr", 32'(overflow), 32'd0);
    check("f_rx_last_clr", 32'(rx_last), 32'd0);
    wr_log.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (12) cyc(1'b0, 1'b1, 8'hA5);
    check_idle("f_run_idle");
    exp_log = '{10'h2B1, 10'h328, 10'h216, 10'h305};
    check_log("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
